// File: rtl/adxl345_ctrl_if.sv
// Parallel request/acknowledge bus between the ADXL345 command sequencer and the SPI PHY.
// One single-byte register transaction per req_o/ack_i pair.
interface adxl345_ctrl_if;
  logic       req_o;
  logic       rw_no;
  logic [5:0] addr_o;
  logic [7:0] wr_data_o;
  logic       ack_i;
  logic [7:0] rd_data_i;

  modport master (
    output req_o, rw_no, addr_o, wr_data_o,
    input  ack_i, rd_data_i
  );

  modport slave (
    input  req_o, rw_no, addr_o, wr_data_o,
    output ack_i, rd_data_i
  );
endinterface

// File: rtl/adxl345_ctrl.sv
// ADXL345 command sequencer: checks DEVID, writes the configuration registers, then
// burst-reads DATAX0..DATAZ1 on every sample tick and publishes X/Y/Z atomically.
module adxl345_ctrl #(
  parameter int unsigned SAMPLE_DIV  = 50000,
  parameter logic [7:0]  FMT_VAL     = 8'h48,
  parameter logic [7:0]  BW_VAL      = 8'h0A,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  adxl345_ctrl_if.master        phy,
  output logic [15:0]           x_o,
  output logic [15:0]           y_o,
  output logic [15:0]           z_o,
  output logic                  valid_o,
  output logic                  init_done_o,
  output logic                  busy_o,
  output logic                  id_err_o,
  output logic                  timeout_o,
  output logic                  overrun_o
);
  localparam logic [7:0]  DevId = 8'hE5;
  localparam int unsigned TmoW  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StIdRd, StCfgFmt, StCfgBw, StCfgPwr, StRunWait, StRdBurst, StPublish, StError
  } state_e;

  state_e          r_state, w_state_nxt;
  logic            r_wait, w_wait_nxt;
  logic            r_stop, w_stop_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [TmoW-1:0] r_tmo_cnt, w_tmo_nxt;
  logic [19:0]     r_tick_cnt;
  logic            r_pend;
  logic [39:0]     r_shadow;
  logic [15:0]     r_x, r_y, r_z;
  logic            r_init_done, r_id_err, r_timeout, r_overrun;

  logic            w_xfer, w_rw, w_ack, w_tmo, w_halt, w_tick;
  logic [5:0]      w_addr;
  logic [7:0]      w_wdata;
  logic [47:0]     w_bytes;
  logic            w_set_id_err, w_pend_clr, w_init_set, w_load, w_run_stop, w_err_exit;

  // Transaction decode; fields stay constant for the whole ISSUE/WAIT_ACK pair.
  always_comb begin
    w_xfer  = 1'b1;
    w_rw    = 1'b1;
    w_addr  = 6'h00;
    w_wdata = 8'h00;
    case (r_state)
      StIdRd:    w_addr = 6'h00;
      StCfgFmt:  begin w_rw = 1'b0; w_addr = 6'h31; w_wdata = FMT_VAL; end
      StCfgBw:   begin w_rw = 1'b0; w_addr = 6'h2C; w_wdata = BW_VAL;  end
      StCfgPwr:  begin w_rw = 1'b0; w_addr = 6'h2D; w_wdata = 8'h08;   end
      StRdBurst: w_addr = 6'h32 + {3'b000, r_idx};
      default:   begin w_xfer = 1'b0; w_rw = 1'b0; end
    endcase
  end

  assign w_ack   = w_xfer & r_wait & phy.ack_i;
  assign w_tmo   = w_xfer & r_wait & ~phy.ack_i & (r_tmo_cnt == TmoW'(ACK_TIMEOUT - 1));
  assign w_halt  = r_stop | ~en_i;
  assign w_tick  = r_init_done & (r_tick_cnt == 20'(SAMPLE_DIV - 1));
  assign w_bytes = {phy.rd_data_i, r_shadow};

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    w_idx_nxt    = r_idx;
    w_tmo_nxt    = r_tmo_cnt;
    w_set_id_err = 1'b0;
    w_pend_clr   = 1'b0;
    // A dropped enable is remembered until the outstanding transaction retires.
    w_stop_nxt   = w_xfer & (r_stop | ~en_i);
    if (w_xfer && !r_wait) begin
      w_wait_nxt = 1'b1;
      w_tmo_nxt  = TmoW'(1);
    end else if (w_xfer) begin
      w_tmo_nxt  = r_tmo_cnt + TmoW'(1);
    end

    if (w_tmo) begin
      w_state_nxt = w_halt ? StIdle : StError;
    end else if (w_ack) begin
      w_wait_nxt = 1'b0;
      unique case (r_state)
        StIdRd: begin
          w_set_id_err = (phy.rd_data_i != DevId);
          w_state_nxt  = w_set_id_err ? StError : StCfgFmt;
        end
        StCfgFmt: w_state_nxt = StCfgBw;
        StCfgBw:  w_state_nxt = StCfgPwr;
        StCfgPwr: w_state_nxt = StRunWait;
        default: begin
          w_idx_nxt = r_idx + 3'd1;
          if (r_idx == 3'd5) w_state_nxt = StPublish;
        end
      endcase
      if (w_halt) w_state_nxt = StIdle;
    end else if (!w_xfer) begin
      case (r_state)
        StIdle: if (en_i) w_state_nxt = StIdRd;
        StRunWait: begin
          if (!en_i) begin
            w_state_nxt = StIdle;
          end else if (r_pend) begin
            w_state_nxt = StRdBurst;
            w_idx_nxt   = 3'd0;
            w_pend_clr  = 1'b1;
          end
        end
        StPublish: w_state_nxt = en_i ? StRunWait : StIdle;
        StError:   if (!en_i) w_state_nxt = StIdle;
        default:   ;
      endcase
    end

    if (w_state_nxt != r_state) begin
      w_wait_nxt = 1'b0;
      w_stop_nxt = 1'b0;
    end
  end

  assign w_init_set = (r_state == StCfgPwr) && (w_state_nxt == StRunWait);
  assign w_load     = (r_state == StRdBurst) && (w_state_nxt == StPublish);
  assign w_err_exit = (r_state == StError) && (w_state_nxt == StIdle);
  // Sampling stops on the way to ERROR as well as to IDLE.
  assign w_run_stop = (w_state_nxt != r_state) &&
                      ((w_state_nxt == StIdle) || (w_state_nxt == StError));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_wait      <= 1'b0;
      r_stop      <= 1'b0;
      r_idx       <= '0;
      r_tmo_cnt   <= '0;
      r_tick_cnt  <= '0;
      r_pend      <= 1'b0;
      r_shadow    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_init_done <= 1'b0;
      r_id_err    <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_stop    <= w_stop_nxt;
      r_idx     <= w_idx_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      if (w_ack && r_state == StRdBurst) r_shadow <= w_bytes[47:8];
      if (w_load) begin
        r_x <= w_bytes[15:0];
        r_y <= w_bytes[31:16];
        r_z <= w_bytes[47:32];
      end
      if (w_run_stop) begin
        r_init_done <= 1'b0;
        r_tick_cnt  <= '0;
        r_pend      <= 1'b0;
      end else if (w_init_set) begin
        r_init_done <= 1'b1;
        r_tick_cnt  <= '0;
      end else if (r_init_done) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 20'd1;
        if (w_tick) begin
          r_pend <= 1'b1;
          if (r_pend && !w_pend_clr) r_overrun <= 1'b1;
        end else if (w_pend_clr) begin
          r_pend <= 1'b0;
        end
      end
      if (w_set_id_err) r_id_err <= 1'b1;
      if (w_tmo) r_timeout <= 1'b1;
      if (w_err_exit) begin
        r_id_err  <= 1'b0;
        r_timeout <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign phy.req_o     = w_xfer & ~r_wait;
  assign phy.rw_no     = w_rw;
  assign phy.addr_o    = w_addr;
  assign phy.wr_data_o = w_wdata;
  assign busy_o        = w_xfer;
  assign valid_o       = (r_state == StPublish);
  assign init_done_o   = r_init_done;
  assign x_o           = r_x;
  assign y_o           = r_y;
  assign z_o           = r_z;
  assign id_err_o      = r_id_err;
  assign timeout_o     = r_timeout;
  assign overrun_o     = r_overrun;
endmodule

// File: tb/tb_adxl345_ctrl.sv
// Bench for adxl345_ctrl: behavioural PHY with a request scoreboard, a sample scoreboard,
// a table of burst vectors and hand sequences for error, disable and reset corners.
module tb_adxl345_ctrl;
  localparam int unsigned SampleDiv  = 32;
  localparam int unsigned AckTimeout = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] x_o, y_o, z_o;
  logic        valid_o, init_done_o, busy_o, id_err_o, timeout_o, overrun_o;

  adxl345_ctrl_if bus ();

  adxl345_ctrl #(
    .SAMPLE_DIV (SampleDiv),
    .ACK_TIMEOUT(AckTimeout)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .phy        (bus),
    .x_o        (x_o),
    .y_o        (y_o),
    .z_o        (z_o),
    .valid_o    (valid_o),
    .init_done_o(init_done_o),
    .busy_o     (busy_o),
    .id_err_o   (id_err_o),
    .timeout_o  (timeout_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic rw; logic [5:0] addr; logic [7:0] wdata; } txn_t;
  typedef struct packed { logic [15:0] x; logic [15:0] y; logic [15:0] z; } smp_t;
  typedef struct packed { logic [47:0] bytes; smp_t exp; } vec_t;

  int   n_vec = 0, n_err = 0, cyc = 0;
  int   n_ack = 0, n_pub = 0, last_req_cyc = 0, last_ack_cyc = 0;
  int   phy_delay = 2;
  bit   chk_txn = 1'b1, noack_en = 1'b0, smp_fixed = 1'b0;
  logic [5:0] noack_addr = 6'h00;
  logic [7:0] mem [64];
  smp_t smp_fix;
  txn_t exp_txn_q[$];
  smp_t exp_smp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return init_done_o;
      1:       return id_err_o;
      2:       return timeout_o;
      3:       return overrun_o;
      default: return ~busy_o;
    endcase
  endfunction

  task automatic wait_hi(input string nm, input int sel, input int budget);
    for (int i = 0; i < budget && sig(sel) !== 1'b1; i++) @(negedge clk_i);
    chk(nm, 32'(sig(sel)), 32'd1);
  endtask

  task automatic wait_pub(input string nm, input int target, input int budget);
    for (int i = 0; i < budget && n_pub < target; i++) @(negedge clk_i);
    chk(nm, 32'(n_pub >= target), 32'd1);
  endtask

  task automatic wait_req(input string nm, input logic [5:0] addr, input int budget);
    for (int i = 0; i < budget && !(bus.req_o === 1'b1 && bus.addr_o == addr); i++)
      @(negedge clk_i);
    chk(nm, 32'(bus.req_o === 1'b1 && bus.addr_o == addr), 32'd1);
  endtask

  // PHY model: checks each request against the expected queue, then acks after phy_delay.
  initial begin : phy_model
    txn_t cur, want;
    bit   skip, held, rst_seen;
    skip = 1'b0;
    bus.ack_i = 1'b0;
    bus.rd_data_i = 8'h00;
    forever begin
      if (!skip) @(negedge clk_i);
      skip = 1'b0;
      if (rst_ni === 1'b1 && bus.req_o === 1'b1) begin
        cur = '{bus.rw_no, bus.addr_o, bus.wr_data_o};
        last_req_cyc = cyc;
        chk("busy_on_req", 32'(busy_o), 32'd1);
        if (chk_txn) begin
          chk("req_expected", 32'(exp_txn_q.size() != 0), 32'd1);
          if (exp_txn_q.size() != 0) begin
            want = exp_txn_q.pop_front();
            chk("req_rw_addr", 32'({cur.rw, cur.addr}), 32'({want.rw, want.addr}));
            if (!want.rw) chk("req_wdata", 32'(cur.wdata), 32'(want.wdata));
          end
        end
        if (noack_en && cur.addr == noack_addr) continue;
        held = 1'b1;
        rst_seen = 1'b0;
        for (int k = 0; k < phy_delay; k++) begin
          @(negedge clk_i);
          if (rst_ni !== 1'b1) rst_seen = 1'b1;
          chk("single_req_cycle", 32'(bus.req_o), 32'd0);
          if ({bus.rw_no, bus.addr_o} != {cur.rw, cur.addr} ||
              (!cur.rw && bus.wr_data_o != cur.wdata)) held = 1'b0;
        end
        bus.ack_i = 1'b1;
        bus.rd_data_i = cur.rw ? mem[cur.addr] : 8'h00;
        n_ack++;
        last_ack_cyc = cyc;
        if (!rst_seen) chk("fields_held", 32'(held), 32'd1);
        @(negedge clk_i);
        bus.ack_i = 1'b0;
        skip = 1'b1;
      end
    end
  end

  initial begin : smp_monitor
    smp_t want;
    forever begin
      @(negedge clk_i);
      if (valid_o === 1'b1) begin
        n_pub++;
        if (smp_fixed) begin
          chk("sample_fixed", 32'({x_o, y_o} != {smp_fix.x, smp_fix.y} || z_o != smp_fix.z),
              32'd0);
        end else begin
          chk("valid_expected", 32'(exp_smp_q.size() != 0), 32'd1);
          if (exp_smp_q.size() != 0) begin
            want = exp_smp_q.pop_front();
            chk("sample_x", 32'(x_o), 32'(want.x));
            chk("sample_y", 32'(y_o), 32'(want.y));
            chk("sample_z", 32'(z_o), 32'(want.z));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish (errors so far %0d)", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs [4];
    int   p0, a0;
    vecs[0] = '{48'h80_00_7F_FF_12_34, '{16'h1234, 16'h7FFF, 16'h8000}};
    vecs[1] = '{48'h00_00_00_00_00_00, '{16'h0000, 16'h0000, 16'h0000}};
    vecs[2] = '{48'hCD_AB_00_01_FF_FF, '{16'hFFFF, 16'h0001, 16'hCDAB}};
    vecs[3] = '{48'h7F_80_3C_C3_A5_5A, '{16'hA55A, 16'h3CC3, 16'h7F80}};
    for (int k = 0; k < 64; k++) mem[k] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_req", 32'(bus.req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_flags", 32'({init_done_o, id_err_o, timeout_o, overrun_o}), 32'd0);
    chk("rst_xyz", 32'({x_o, y_o} | 32'(z_o)), 32'd0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("idle_no_req", 32'(bus.req_o), 32'd0);

    // Bad device ID
    mem[0] = 8'hE4;
    exp_txn_q.push_back('{1'b1, 6'h00, 8'h00});
    en_i = 1'b1;
    @(negedge clk_i);
    chk("en_to_req_latency", 32'(bus.req_o), 32'd1);
    wait_hi("id_err_set", 1, 50);
    chk("badid_no_init", 32'(init_done_o), 32'd0);
    repeat (20) @(negedge clk_i);
    chk("badid_no_writes", 32'(exp_txn_q.size()), 32'd0);
    chk("badid_idle_bus", 32'(busy_o), 32'd0);
    en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("badid_cleared", 32'(id_err_o), 32'd0);

    // Init sequence and table-driven sample bursts
    mem[0] = 8'hE5;
    exp_txn_q.push_back('{1'b1, 6'h00, 8'h00});
    exp_txn_q.push_back('{1'b0, 6'h31, 8'h48});
    exp_txn_q.push_back('{1'b0, 6'h2C, 8'h0A});
    exp_txn_q.push_back('{1'b0, 6'h2D, 8'h08});
    a0 = n_ack;
    en_i = 1'b1;
    wait_hi("init_done_set", 0, 100);
    chk("init_ack_count", 32'(n_ack - a0), 32'd4);
    chk("init_done_after_4th_ack", 32'(cyc - last_ack_cyc), 32'd1);
    chk("init_txns_consumed", 32'(exp_txn_q.size()), 32'd0);
    p0 = n_pub;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 6; k++) begin
        mem[6'h32 + 6'(k)] = vecs[i].bytes[8*k +: 8];
        exp_txn_q.push_back('{1'b1, 6'h32 + 6'(k), 8'h00});
      end
      exp_smp_q.push_back(vecs[i].exp);
      wait_pub("sample_published", p0 + i + 1, 200);
    end
    en_i = 1'b0;
    repeat (50) @(negedge clk_i);
    chk("one_valid_per_tick", 32'(n_pub - p0), 32'd4);
    chk("burst_txns_consumed", 32'(exp_txn_q.size()), 32'd0);
    chk("no_overrun_fast_phy", 32'(overrun_o), 32'd0);
    chk("disable_init_low", 32'(init_done_o), 32'd0);

    // Ack timeout on the BW_RATE write
    exp_txn_q.push_back('{1'b1, 6'h00, 8'h00});
    exp_txn_q.push_back('{1'b0, 6'h31, 8'h48});
    exp_txn_q.push_back('{1'b0, 6'h2C, 8'h0A});
    noack_addr = 6'h2C;
    noack_en = 1'b1;
    en_i = 1'b1;
    wait_hi("timeout_set", 2, 300);
    chk("timeout_latency", 32'(cyc - last_req_cyc), 32'(AckTimeout));
    chk("timeout_busy_low", 32'(busy_o), 32'd0);
    repeat (30) @(negedge clk_i);
    chk("timeout_no_more_req", 32'(exp_txn_q.size()), 32'd0);
    noack_en = 1'b0;
    en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("timeout_cleared", 32'(timeout_o), 32'd0);

    // Overrun with a slow PHY; samples keep publishing
    for (int k = 0; k < 6; k++) mem[6'h32 + 6'(k)] = vecs[0].bytes[8*k +: 8];
    phy_delay = 10;
    chk_txn = 1'b0;
    smp_fix = vecs[0].exp;
    smp_fixed = 1'b1;
    en_i = 1'b1;
    wait_hi("overrun_set", 3, 800);
    p0 = n_pub;
    wait_pub("publish_during_overrun", p0 + 2, 400);
    en_i = 1'b0;
    wait_hi("overrun_bus_drained", 4, 100);
    repeat (3) @(negedge clk_i);
    chk("overrun_sticky", 32'(overrun_o), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("overrun_reset_clear", 32'(overrun_o), 32'd0);
    rst_ni = 1'b1;
    phy_delay = 2;
    chk_txn = 1'b1;
    smp_fixed = 1'b0;
    repeat (2) @(negedge clk_i);

    // Disable during the third data read
    exp_txn_q.push_back('{1'b1, 6'h00, 8'h00});
    exp_txn_q.push_back('{1'b0, 6'h31, 8'h48});
    exp_txn_q.push_back('{1'b0, 6'h2C, 8'h0A});
    exp_txn_q.push_back('{1'b0, 6'h2D, 8'h08});
    for (int k = 0; k < 3; k++) exp_txn_q.push_back('{1'b1, 6'h32 + 6'(k), 8'h00});
    a0 = n_ack;
    p0 = n_pub;
    en_i = 1'b1;
    wait_req("third_read_req", 6'h34, 300);
    @(negedge clk_i);
    en_i = 1'b0;
    repeat (60) @(negedge clk_i);
    chk("disable_ack_consumed", 32'(n_ack - a0), 32'd7);
    chk("disable_no_4th_req", 32'(exp_txn_q.size()), 32'd0);
    chk("disable_no_valid", 32'(n_pub - p0), 32'd0);
    chk("disable_init_clear", 32'(init_done_o), 32'd0);
    chk("disable_busy_low", 32'(busy_o), 32'd0);

    // Reset in the middle of a transaction
    phy_delay = 6;
    exp_txn_q.push_back('{1'b1, 6'h00, 8'h00});
    en_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("midtxn_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_req", 32'(bus.req_o), 32'd0);
    chk("midrst_xyz", 32'({x_o, y_o} | 32'(z_o)), 32'd0);
    chk("midrst_flags", 32'({valid_o, init_done_o, id_err_o, timeout_o, overrun_o}), 32'd0);
    en_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("post_rst_idle", 32'(busy_o), 32'd0);
    chk("post_rst_queue", 32'(exp_txn_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
